// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: opcode/funct constants and the request record.
package alu_issue_stage_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } Funct3_Op;

  typedef enum logic [2:0] {
    F3M_MUL    = 3'b000,
    F3M_MULH   = 3'b001,
    F3M_MULHSU = 3'b010,
    F3M_MULHU  = 3'b011,
    F3M_DIV    = 3'b100,
    F3M_DIVU   = 3'b101,
    F3M_REM    = 3'b110,
    F3M_REMU   = 3'b111
  } Funct3_M;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            width_32;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } alu_req_t;

  function automatic logic funct7Known(input logic [6:0] f7);
    return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MEXT);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV64IM ALU decode: raw instruction plus operands into one ALU request.
module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [ILEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output alu_req_t        req_o
);

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] immI;
  logic [XLEN-1:0] immU;
  logic            isShift;

  assign opcode  = inst_i[6:0];
  assign funct3  = inst_i[14:12];
  assign funct7  = inst_i[31:25];
  assign immI    = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign immU    = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
  assign isShift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [2:0]      opF3;
  logic [6:0]      opF7;
  logic            opW;
  logic            legal;

  always_comb begin
    opA   = '0;
    opB   = '0;
    opF3  = funct3;
    opF7  = F7_BASE;
    opW   = 1'b0;
    legal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        opA   = rs1_i;
        opB   = rs2_i;
        opF7  = funct7;
        opW   = (opcode == OPC_OP_32);
        legal = funct7Known(funct7);
        if (funct7 == F7_ALT && funct3 != F3_ADD && funct3 != F3_SR) legal = 1'b0;
        // W-forms only have add/sub and shifts, plus the 32-bit M ops (no high multiplies)
        if (opcode == OPC_OP_32) begin
          if (funct7 == F7_MEXT) begin
            if (funct3 == F3M_MULH || funct3 == F3M_MULHSU || funct3 == F3M_MULHU) legal = 1'b0;
          end else if (!(funct3 == F3_ADD || isShift)) begin
            legal = 1'b0;
          end
        end
      end
      OPC_OP_IMM: begin
        opA   = rs1_i;
        opB   = immI;
        legal = 1'b1;
        if (isShift) begin
          opF7  = {inst_i[31:26], 1'b0};
          opB   = {{(XLEN-6){1'b0}}, inst_i[25:20]};
          legal = funct7Known(opF7) && !(opF7 == F7_ALT && funct3 != F3_SR);
        end
      end
      OPC_OP_IMM_32: begin
        opA   = rs1_i;
        opB   = immI;
        opW   = 1'b1;
        legal = (funct3 == F3_ADD) || isShift;
        if (isShift) begin
          opF7 = funct7;
          opB  = {{(XLEN-5){1'b0}}, inst_i[24:20]};
          if (inst_i[25] || !funct7Known(funct7)) legal = 1'b0;
          if (funct7 == F7_ALT && funct3 != F3_SR) legal = 1'b0;
        end
      end
      OPC_LUI: begin
        opB   = immU;
        opF3  = F3_ADD;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        opA   = pc_i;
        opB   = immU;
        opF3  = F3_ADD;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal requests still carry rd/pc/op so the trap path can identify them
  always_comb begin
    req_o.a        = legal ? opA  : '0;
    req_o.b        = legal ? opB  : '0;
    req_o.funct3   = legal ? opF3 : 3'b0;
    req_o.funct7   = legal ? opF7 : 7'b0;
    req_o.width_32 = legal & opW;
    req_o.op       = opcode;
    req_o.rd       = inst_i[11:7];
    req_o.pc       = pc_i;
    req_o.illegal  = ~legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes requests and holds them in an output register backed by one skid slot.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_width_32,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  alu_req_t decReq;
  alu_req_t outReq_q, outReq_d;
  alu_req_t skidReq_q, skidReq_d;
  logic     outValid_q, outValid_d;
  logic     skidValid_q, skidValid_d;
  logic     inReady_q, inReady_d;
  logic     accept;
  logic     transfer;

  alu_op_decode u_decode (
    .inst_i (in_inst),
    .pc_i   (in_pc),
    .rs1_i  (in_rs1_val),
    .rs2_i  (in_rs2_val),
    .req_o  (decReq)
  );

  assign accept   = in_valid & inReady_q;
  assign transfer = outValid_q & out_ready;

  // Skid can only be full while the output slot is full and stalled, so it never collides with an accept
  always_comb begin
    outReq_d    = outReq_q;
    skidReq_d   = skidReq_q;
    outValid_d  = outValid_q;
    skidValid_d = skidValid_q;
    if (flush) begin
      outValid_d  = 1'b0;
      skidValid_d = 1'b0;
    end else if (!outValid_q || transfer) begin
      if (skidValid_q) begin
        outReq_d    = skidReq_q;
        outValid_d  = 1'b1;
        skidValid_d = 1'b0;
      end else begin
        outValid_d = accept;
        if (accept) outReq_d = decReq;
      end
    end else if (accept) begin
      skidReq_d   = decReq;
      skidValid_d = 1'b1;
    end
    inReady_d = ~skidValid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outReq_q    <= '0;
      skidReq_q   <= '0;
      outValid_q  <= 1'b0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b0;
    end else begin
      outReq_q    <= outReq_d;
      skidReq_q   <= skidReq_d;
      outValid_q  <= outValid_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= inReady_d;
    end
  end

  assign in_ready     = inReady_q;
  assign out_valid    = outValid_q;
  assign out_a        = outReq_q.a;
  assign out_b        = outReq_q.b;
  assign out_funct3   = outReq_q.funct3;
  assign out_funct7   = outReq_q.funct7;
  assign out_width_32 = outReq_q.width_32;
  assign out_op       = outReq_q.op;
  assign out_rd       = outReq_q.rd;
  assign out_pc       = outReq_q.pc;
  assign out_illegal  = outReq_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table, directed handshake/flush/reset sequences, random FIFO run.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [63:0] in_rs1_val;
  logic [63:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_width_32;
  logic [6:0]  out_op;
  logic [4:0]  out_rd;
  logic [63:0] out_pc;
  logic        out_illegal;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .in_rs1_val   (in_rs1_val),
    .in_rs2_val   (in_rs2_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7),
    .out_width_32 (out_width_32),
    .out_op       (out_op),
    .out_rd       (out_rd),
    .out_pc       (out_pc),
    .out_illegal  (out_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        w;
    logic        ill;
    logic [4:0]  rd;
  } vec_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        w;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  localparam logic [63:0] RS1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RS2 = 64'h5555_6666_7777_8888;
  localparam logic [31:0] ADDI_M1 = 32'hFFF10093;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] rs1, input logic [63:0] rs2);
    in_valid   = v;
    in_inst    = inst;
    in_pc      = pc;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] rs1,
                                 input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic w, input logic ill, input logic [4:0] rd);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = RS2;
    v.a = a; v.b = b; v.f3 = f3; v.f7 = f7; v.w = w; v.ill = ill; v.rd = rd;
    return v;
  endfunction

  // Reference decode written straight from the ISA rules
  function automatic exp_t modelDecode(input logic [31:0] inst, input logic [63:0] pc,
                                       input logic [63:0] rs1, input logic [63:0] rs2);
    exp_t e;
    logic [6:0] opc = inst[6:0];
    logic [6:0] f7  = inst[31:25];
    logic [2:0] f3  = inst[14:12];
    logic [63:0] iImm = {{52{inst[31]}}, inst[31:20]};
    logic [63:0] uImm = {{32{inst[31]}}, inst[31:12], 12'h000};
    logic shift = (f3 == 3'd1) || (f3 == 3'd5);
    logic ok = 1'b1;
    e = '0;
    e.op = opc; e.rd = inst[11:7]; e.pc = pc;
    case (opc)
      7'h33, 7'h3B: begin
        e.a = rs1; e.b = rs2; e.f3 = f3; e.f7 = f7; e.w = (opc == 7'h3B);
        if (!(f7 inside {7'h00, 7'h20, 7'h01})) ok = 1'b0;
        if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) ok = 1'b0;
        if (opc == 7'h3B) begin
          if (f7 == 7'h01) begin
            if (f3 inside {3'd1, 3'd2, 3'd3}) ok = 1'b0;
          end else if (!(f3 inside {3'd0, 3'd1, 3'd5})) ok = 1'b0;
        end
      end
      7'h13: begin
        e.a = rs1; e.f3 = f3; e.b = iImm;
        if (shift) begin
          e.f7 = {inst[31:26], 1'b0};
          e.b  = {58'd0, inst[25:20]};
          ok   = (e.f7 == 7'h00) || (e.f7 == 7'h20 && f3 == 3'd5);
        end
      end
      7'h1B: begin
        e.a = rs1; e.f3 = f3; e.w = 1'b1; e.b = iImm;
        if (shift) begin
          e.f7 = f7;
          e.b  = {59'd0, inst[24:20]};
          ok   = !inst[25] && ((f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5));
        end else ok = (f3 == 3'd0);
      end
      7'h37: e.b = uImm;
      7'h17: begin e.a = pc; e.b = uImm; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.a = '0; e.b = '0; e.f3 = '0; e.f7 = '0; e.w = 1'b0;
    end
    e.ill = !ok;
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [6:0] opc;
    logic [6:0] f7;
    case ($urandom_range(0, 7))
      0: opc = 7'h33;
      1: opc = 7'h3B;
      2: opc = 7'h13;
      3: opc = 7'h1B;
      4: opc = 7'h37;
      5: opc = 7'h17;
      6: opc = 7'h63;
      default: opc = 7'h03;
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  function automatic logic [255:0] actualOut();
    exp_t e;
    e.a = out_a; e.b = out_b; e.f3 = out_funct3; e.f7 = out_funct7; e.w = out_width_32;
    e.op = out_op; e.rd = out_rd; e.pc = out_pc; e.ill = out_illegal;
    return 256'(e);
  endfunction

  vec_t vecs[$];
  exp_t q[$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back(mkVec(ADDI_M1,      64'h1000, 64'd5, 64'd5, '1, 3'd0, 7'h00, 1'b0, 1'b0, 5'd1));
    vecs.push_back(mkVec(32'h43F25193, 64'h1000, RS1, RS1, 64'd63, 3'd5, 7'h20, 1'b0, 1'b0, 5'd3));
    vecs.push_back(mkVec(32'h4083833B, 64'h1000, RS1, RS1, RS2, 3'd0, 7'h20, 1'b1, 1'b0, 5'd6));
    vecs.push_back(mkVec(32'h800002B7, 64'h1000, RS1, 64'd0, 64'hFFFF_FFFF_8000_0000, 3'd0, 7'h00, 1'b0, 1'b0, 5'd5));
    vecs.push_back(mkVec(32'h80000297, 64'h1000, RS1, 64'h1000, 64'hFFFF_FFFF_8000_0000, 3'd0, 7'h00, 1'b0, 1'b0, 5'd5));
    vecs.push_back(mkVec(32'h0020A4BB, 64'h2468, RS1, 64'd0, 64'd0, 3'd0, 7'h00, 1'b0, 1'b1, 5'd9));
    vecs.push_back(mkVec(32'h00208063, 64'h3000, RS1, 64'd0, 64'd0, 3'd0, 7'h00, 1'b0, 1'b1, 5'd0));
    vecs.push_back(mkVec(32'h40000093, 64'h1000, RS1, RS1, 64'h400, 3'd0, 7'h00, 1'b0, 1'b0, 5'd1));
    vecs.push_back(mkVec(32'h023100BB, 64'h1000, RS1, RS1, RS2, 3'd0, 7'h01, 1'b1, 1'b0, 5'd1));
    vecs.push_back(mkVec(32'h0211109B, 64'h1000, RS1, 64'd0, 64'd0, 3'd0, 7'h00, 1'b0, 1'b1, 5'd1));
    vecs.push_back(mkVec(32'h4051509B, 64'h1000, RS1, RS1, 64'd5, 3'd5, 7'h20, 1'b1, 1'b0, 5'd1));
    vecs.push_back(mkVec(32'h40209033, 64'h1000, RS1, 64'd0, 64'd0, 3'd0, 7'h00, 1'b0, 1'b1, 5'd0));
    vecs.push_back(mkVec(32'h40111093, 64'h1000, RS1, 64'd0, 64'd0, 3'd0, 7'h00, 1'b0, 1'b1, 5'd1));
    vecs.push_back(mkVec(32'h04208033, 64'h1000, RS1, 64'd0, 64'd0, 3'd0, 7'h00, 1'b0, 1'b1, 5'd0));

    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
    step(); step(); step();
    checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
    checkOutput("rst_in_ready", 256'(in_ready), 256'(0));
    checkOutput("rst_data", actualOut(), 256'(0));
    reset = 1'b1;
    step();
    checkOutput("rel_in_ready", 256'(in_ready), 256'(1));
    checkOutput("rel_out_valid", 256'(out_valid), 256'(0));

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      step();
      checkOutput($sformatf("vec%0d_valid", i), 256'(out_valid), 256'(1));
      checkOutput($sformatf("vec%0d_a", i), 256'(out_a), 256'(vecs[i].a));
      checkOutput($sformatf("vec%0d_b", i), 256'(out_b), 256'(vecs[i].b));
      checkOutput($sformatf("vec%0d_f3f7w", i), 256'({out_funct3, out_funct7, out_width_32}),
                  256'({vecs[i].f3, vecs[i].f7, vecs[i].w}));
      checkOutput($sformatf("vec%0d_ill", i), 256'(out_illegal), 256'(vecs[i].ill));
      checkOutput($sformatf("vec%0d_rd_pc_op", i), 256'({out_rd, out_pc, out_op}),
                  256'({vecs[i].rd, vecs[i].pc, vecs[i].inst[6:0]}));
    end
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
    step();
    checkOutput("drain_valid", 256'(out_valid), 256'(0));

    // Backpressure: R1 in out, R2 in skid, R3 held upstream, then drain in order
    out_ready = 1'b0;
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h11, 64'd0);
    step();
    checkOutput("bp_r1_valid", 256'(out_valid), 256'(1));
    checkOutput("bp_r1_a", 256'(out_a), 256'(64'h11));
    checkOutput("bp_r1_ready", 256'(in_ready), 256'(1));
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h22, 64'd0);
    step();
    checkOutput("bp_r2_ready", 256'(in_ready), 256'(0));
    checkOutput("bp_r2_hold_a", 256'(out_a), 256'(64'h11));
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h33, 64'd0);
    step();
    checkOutput("bp_r3_ready", 256'(in_ready), 256'(0));
    checkOutput("bp_r3_hold_a", 256'(out_a), 256'(64'h11));
    out_ready = 1'b1;
    step();
    checkOutput("bp_out_r2", 256'(out_a), 256'(64'h22));
    checkOutput("bp_out_r2_ready", 256'(in_ready), 256'(1));
    step();
    checkOutput("bp_out_r3", 256'(out_a), 256'(64'h33));
    checkOutput("bp_out_r3_valid", 256'(out_valid), 256'(1));
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
    step();
    checkOutput("bp_empty", 256'(out_valid), 256'(0));

    // Flush with out and skid full, then flush against an accept that must be dropped
    out_ready = 1'b0;
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h44, 64'd0);
    step();
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h55, 64'd0);
    step();
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h66, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("fl_full_valid", 256'(out_valid), 256'(0));
    checkOutput("fl_full_ready", 256'(in_ready), 256'(1));
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
    step();
    checkOutput("fl_full_after", 256'(out_valid), 256'(0));
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h77, 64'd0);
    step();
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h88, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("fl_acc_valid", 256'(out_valid), 256'(0));
    checkOutput("fl_acc_ready", 256'(in_ready), 256'(1));
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
    step();
    checkOutput("fl_acc_dropped", 256'(out_valid), 256'(0));

    // Reset asserted mid-stall
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'h99, 64'd0);
    step();
    applyStimulus(1'b1, ADDI_M1, 64'd0, 64'hAA, 64'd0);
    step();
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 64'd0);
    reset = 1'b0;
    step();
    checkOutput("mrst_valid", 256'(out_valid), 256'(0));
    checkOutput("mrst_ready", 256'(in_ready), 256'(0));
    checkOutput("mrst_a", 256'(out_a), 256'(0));
    step();
    checkOutput("mrst_ready_hold", 256'(in_ready), 256'(0));
    reset = 1'b1;
    step();
    checkOutput("mrst_rel_ready", 256'(in_ready), 256'(1));
    checkOutput("mrst_rel_valid", 256'(out_valid), 256'(0));

    // Random traffic against a two-entry FIFO model
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] r1;
      logic [63:0] r2;
      logic        v;
      logic        rdy;
      logic        acc;
      logic        xfer;
      checkOutput("rnd_out_valid", 256'(out_valid), 256'(q.size() > 0));
      checkOutput("rnd_in_ready", 256'(in_ready), 256'(q.size() < 2));
      if (q.size() > 0) checkOutput("rnd_data", actualOut(), 256'(q[0]));
      inst = randInst();
      pc   = {$urandom, $urandom};
      r1   = {$urandom, $urandom};
      r2   = {$urandom, $urandom};
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      applyStimulus(v, inst, pc, r1, r2);
      out_ready = rdy;
      acc  = v && (q.size() < 2);
      xfer = rdy && (q.size() > 0);
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(modelDecode(inst, pc, r1, r2));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
